// File: rtl/auth_pkg.sv
// Shared types and default command codes for the authenticated power-up command block.
package auth_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_KEY  = 2'd1,
    ST_PWR1 = 2'd2,
    ST_PWR2 = 2'd3
  } auth_state_t;

  localparam logic [7:0] GO_CODE_DEF   = 8'h47;
  localparam logic [7:0] STOP_CODE_DEF = 8'h53;

  function automatic logic is_powered(input auth_state_t s);
    return (s == ST_PWR1) || (s == ST_PWR2);
  endfunction

endpackage

// File: rtl/auth_wdog.sv
// Saturating link watchdog: counts idle cycles, expire holds while the count sits at its ceiling.
module auth_wdog #(
  parameter int unsigned WDOG_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expire
);

  localparam int unsigned    CNT_W   = $clog2(WDOG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WDOG_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign expire = (count_q == CNT_MAX);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (!expire) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/auth_cmd_blk.sv
// UART command decoder gating balance-control power, with link watchdog.
// Define AUTH_PIN_EN to require a KEY_LEN-byte PIN after GO_CODE.
module auth_cmd_blk
  import auth_pkg::*;
#(
  parameter logic [7:0]           GO_CODE     = GO_CODE_DEF,
  parameter logic [7:0]           STOP_CODE   = STOP_CODE_DEF,
  parameter int unsigned          KEY_LEN     = 2,
  parameter logic [KEY_LEN*8-1:0] PIN         = 16'h3141,
  parameter int unsigned          WDOG_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  input  logic       rider_off,
  output logic       clr_rx_rdy,
  output logic       pwr_up,
  output logic       link_lost,
  output logic       cmd_err
);

  auth_state_t state_q, state_d;
  logic        pwr_up_q, pwr_up_d;
  logic        link_lost_q, link_lost_d;
  logic        cmd_err_q, cmd_err_d;
  logic        wdog_clr, wdog_exp;
  logic        is_go, is_stop;

  assign is_go      = (rx_data == GO_CODE);
  assign is_stop    = (rx_data == STOP_CODE);
  assign clr_rx_rdy = rx_rdy && !rst;
  assign pwr_up     = pwr_up_q;
  assign link_lost  = link_lost_q;
  assign cmd_err    = cmd_err_q;

`ifdef AUTH_PIN_EN
  localparam int unsigned IDX_W = $clog2(KEY_LEN) + 1;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       pin_byte;

  // PIN is sent MSB first, so idx 0 selects the top byte.
  always_comb begin
    pin_byte = '0;
    for (int unsigned i = 0; i < KEY_LEN; i++) begin
      if (idx_q == IDX_W'(i)) begin
        pin_byte = PIN[8*(KEY_LEN-1-i) +: 8];
      end
    end
  end
`else
  logic unused_pin_cfg;
  assign unused_pin_cfg = ^PIN;
`endif

  auth_wdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clear (wdog_clr),
    .expire(wdog_exp)
  );

  // A received byte always wins over a coincident watchdog expiry.
  always_comb begin
    state_d     = state_q;
    link_lost_d = link_lost_q;
    cmd_err_d   = 1'b0;
`ifdef AUTH_PIN_EN
    idx_d       = idx_q;
`endif
    if (rx_rdy) begin
      case (state_q)
        ST_OFF: begin
          if (is_go) begin
`ifdef AUTH_PIN_EN
            state_d = ST_KEY;
            idx_d   = '0;
`else
            state_d = ST_PWR1;
`endif
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        ST_KEY: begin
`ifdef AUTH_PIN_EN
          if (rx_data == pin_byte) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_W'(KEY_LEN - 1)) begin
              state_d = ST_PWR1;
            end
          end else begin
            state_d   = ST_OFF;
            idx_d     = '0;
            cmd_err_d = 1'b1;
          end
`else
          state_d = ST_OFF;
`endif
        end
        ST_PWR1: begin
          if (is_stop) begin
            state_d = rider_off ? ST_OFF : ST_PWR2;
          end else if (!is_go) begin
            cmd_err_d = 1'b1;
          end
        end
        ST_PWR2: begin
          if (is_go) begin
            state_d = ST_PWR1;
          end else if (!is_stop) begin
            cmd_err_d = 1'b1;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end else if (wdog_exp) begin
      if (state_q == ST_KEY) begin
        state_d   = ST_OFF;
        cmd_err_d = 1'b1;
`ifdef AUTH_PIN_EN
        idx_d     = '0;
`endif
      end else if (state_q == ST_PWR1) begin
        state_d     = ST_PWR2;
        link_lost_d = 1'b1;
      end
    end

    // Pending stop completes as soon as the rider steps off, whatever else arrived.
    if ((state_q == ST_PWR2) && rider_off) begin
      state_d = ST_OFF;
    end
    if ((state_d == ST_PWR1) && (state_q != ST_PWR1)) begin
      link_lost_d = 1'b0;
    end

    pwr_up_d = is_powered(state_d);
    wdog_clr = rx_rdy || (state_q == ST_OFF) || (state_d == ST_OFF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_OFF;
      pwr_up_q    <= 1'b0;
      link_lost_q <= 1'b0;
      cmd_err_q   <= 1'b0;
`ifdef AUTH_PIN_EN
      idx_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pwr_up_q    <= pwr_up_d;
      link_lost_q <= link_lost_d;
      cmd_err_q   <= cmd_err_d;
`ifdef AUTH_PIN_EN
      idx_q       <= idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_auth_cmd_blk.sv
// Directed plus randomized bench for auth_cmd_blk against a behavioural model.
module tb_auth_cmd_blk;

  localparam logic [7:0]  GO      = 8'h47;
  localparam logic [7:0]  STOP    = 8'h53;
  localparam int unsigned KEY_LEN = 2;
  localparam logic [15:0] PIN     = 16'h3141;
  localparam int          WDOG    = 1000;
`ifdef AUTH_PIN_EN
  localparam bit PIN_EN = 1'b1;
`else
  localparam bit PIN_EN = 1'b0;
`endif

  localparam int M_OFF = 0, M_KEY = 1, M_RUN = 2, M_PEND = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       rider_off;
  logic       clr_rx_rdy, pwr_up, link_lost, cmd_err;

  int checks = 0;
  int errors = 0;

  int m_mode, m_pos, m_idle;
  bit m_lost, e_pwr, e_err;

  always #5 clk = ~clk;

  auth_cmd_blk #(
    .GO_CODE(GO), .STOP_CODE(STOP), .KEY_LEN(KEY_LEN), .PIN(PIN), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .rider_off(rider_off),
    .clr_rx_rdy(clr_rx_rdy), .pwr_up(pwr_up), .link_lost(link_lost), .cmd_err(cmd_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] pin_byte(input int pos);
    logic [15:0] p;
    p = PIN;
    return 8'(p >> (8 * (KEY_LEN - 1 - pos)));
  endfunction

  // Behavioural reference: one call per clock with the inputs seen at that edge.
  task automatic model_step(input logic [7:0] b, input bit rdy, input bit rider);
    int  old;
    bit  expired;
    old     = m_mode;
    expired = (m_idle == WDOG - 1);
    e_err   = 1'b0;
    if (rdy) begin
      if (old == M_OFF) begin
        if (b == GO) begin
          if (PIN_EN) begin m_mode = M_KEY; m_pos = 0; end
          else m_mode = M_RUN;
        end else e_err = 1'b1;
      end else if (old == M_KEY) begin
        if (b == pin_byte(m_pos)) begin
          m_pos++;
          if (m_pos == KEY_LEN) m_mode = M_RUN;
        end else begin
          m_mode = M_OFF; m_pos = 0; e_err = 1'b1;
        end
      end else if (b == STOP) begin
        if (old == M_RUN) m_mode = rider ? M_OFF : M_PEND;
      end else if (b == GO) begin
        m_mode = M_RUN;
      end else begin
        e_err = 1'b1;
      end
    end else if (expired) begin
      if (old == M_KEY) begin m_mode = M_OFF; e_err = 1'b1; end
      else if (old == M_RUN) begin m_mode = M_PEND; m_lost = 1'b1; end
    end
    if (old == M_PEND && rider) m_mode = M_OFF;
    if (m_mode == M_RUN && old != M_RUN) m_lost = 1'b0;
    if (rdy || old == M_OFF || m_mode == M_OFF) m_idle = 0;
    else if (m_idle < WDOG - 1) m_idle++;
    e_pwr = (m_mode == M_RUN) || (m_mode == M_PEND);
  endtask

  task automatic cycle(input logic [7:0] b, input bit rdy, input bit rider);
    rx_data = b; rx_rdy = rdy; rider_off = rider;
    #1;
    chk("clr_rx_rdy", clr_rx_rdy, rdy);
    model_step(b, rdy, rider);
    @(posedge clk); #1;
    chk("pwr_up", pwr_up, e_pwr);
    chk("link_lost", link_lost, m_lost);
    chk("cmd_err", cmd_err, e_err);
  endtask

  task automatic send(input logic [7:0] b);
    cycle(b, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n, input bit rider);
    for (int i = 0; i < n; i++) cycle(8'h00, 1'b0, rider);
  endtask

  task automatic power_on();
    send(GO);
    if (PIN_EN) begin
      for (int i = 0; i < KEY_LEN; i++) send(pin_byte(i));
    end
  endtask

  // Reset is applied while a GO byte is presented; it must be ignored and not consumed.
  task automatic do_reset();
    rst = 1'b1; rx_data = GO; rx_rdy = 1'b1; rider_off = 1'b0;
    #1;
    chk("rst_clr_rx_rdy", clr_rx_rdy, 1'b0);
    chk("rst_pwr_up", pwr_up, 1'b0);
    chk("rst_link_lost", link_lost, 1'b0);
    chk("rst_cmd_err", cmd_err, 1'b0);
    m_mode = M_OFF; m_pos = 0; m_idle = 0; m_lost = 1'b0;
    @(posedge clk); #1;
    chk("rst_hold_pwr_up", pwr_up, 1'b0);
    @(negedge clk);
    rst = 1'b0; rx_rdy = 1'b0;
  endtask

  initial begin
    int got;
    logic [7:0] b;
    rst = 1'b1; rx_data = 8'h00; rx_rdy = 1'b0; rider_off = 1'b0;
    do_reset();

    // Power-up path; without PIN, GO alone powers up one edge later.
    send(GO);
    chk("go_pwr_up", pwr_up, PIN_EN ? 1'b0 : 1'b1);
    chk("go_cmd_err", cmd_err, 1'b0);
`ifdef AUTH_PIN_EN
    send(8'h31);
    chk("pin1_pwr_up", pwr_up, 1'b0);
    send(8'h41);
    chk("pin2_pwr_up", pwr_up, 1'b1);
`endif
    send(STOP);
    chk("stop_no_rider_pwr_up", pwr_up, 1'b1);
    cycle(8'h00, 1'b0, 1'b1);
    chk("rider_off_pwr_up", pwr_up, 1'b0);

    // Wrong PIN byte (or, without PIN, stray bytes while powered).
    send(GO); send(8'h31); send(8'h42);
    chk("badpin_cmd_err", cmd_err, 1'b1);
`ifdef AUTH_PIN_EN
    chk("badpin_pwr_up", pwr_up, 1'b0);
`endif
    send(STOP); cycle(8'h00, 1'b0, 1'b1);

    // Link watchdog: expiry after exactly WDOG idle edges while running.
    power_on();
    got = -1;
    for (int n = 1; n <= WDOG + 100; n++) begin
      cycle(8'h00, 1'b0, 1'b0);
      if (link_lost === 1'b1) begin got = n; break; end
    end
    chk("wdog_expiry_edges", got, WDOG);
    chk("wdog_pwr_up_held", pwr_up, 1'b1);
    cycle(8'h00, 1'b0, 1'b0);
    send(GO);
    chk("regain_link_lost", link_lost, 1'b0);
    chk("regain_pwr_up", pwr_up, 1'b1);

    // Byte arriving in the expiry cycle cancels the expiry.
    idle(WDOG - 1, 1'b0);
    send(8'h00);
    chk("edge_byte_link_lost", link_lost, 1'b0);
    chk("edge_byte_cmd_err", cmd_err, 1'b1);
    idle(5, 1'b0);
    chk("edge_byte_still_lost0", link_lost, 1'b0);
    cycle(STOP, 1'b1, 1'b1);
    chk("stop_with_rider", pwr_up, 1'b0);

    // Watchdog during PIN entry (or while powered without PIN).
    send(GO);
    idle(WDOG + 2, 1'b0);
    send(STOP); cycle(8'h00, 1'b0, 1'b1);

    // Reset in the middle of a PIN sequence.
    send(GO); send(8'h31);
    do_reset();
    send(8'h31);
    chk("post_rst_cmd_err", cmd_err, 1'b1);
    chk("post_rst_pwr_up", pwr_up, 1'b0);

    // Randomized traffic with occasional long silences and one reset.
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < 600; i++) begin
        case ($urandom_range(0, 5))
          0, 1:    b = GO;
          2:       b = STOP;
          3:       b = 8'h31;
          4:       b = 8'h41;
          default: b = 8'($urandom);
        endcase
        cycle(b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
      end
      if (blk == 3) do_reset();
      power_on();
      idle(int'($urandom_range(WDOG - 5, WDOG + 5)), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
